// File: rtl/mc_controller_hs.sv
// mc_controller_hs: multicycle RISC-V control FSM with memory handshake, wait timeout and retire counter
module mc_controller_hs #(
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       op,
    input  logic [2:0]       funct3,
    input  logic             funct7b5,
    input  logic             Zero,
    input  logic             mem_ready,
    output logic             MemReq,
    output logic             PCWrite,
    output logic             AdrSrc,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             RegWrite,
    output logic [1:0]       ResultSrc,
    output logic [1:0]       ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ImmSrc,
    output logic [2:0]       ALUControl,
    output logic [CNT_W-1:0] instret,
    output logic             mem_timeout,
    output logic             illegal_op,
    output logic [3:0]       state
);
    localparam int WW = $clog2(TIMEOUT + 1);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECR    = 4'd6,
        ALUWB    = 4'd7,
        EXECI    = 4'd8,
        JAL      = 4'd9,
        BEQ      = 4'd10,
        HALT     = 4'd11
    } state_t;

    state_t        cur, nxt;
    logic [WW-1:0] wait_cnt;
    logic [1:0]    alu_op;
    logic          mem_st, tmo, bad_op;

    assign state  = cur;
    assign mem_st = cur == FETCH || cur == MEMREAD || cur == MEMWRITE;
    // completion in the same cycle as the last allowed wait wins over the timeout
    assign tmo    = mem_st && !mem_ready && wait_cnt == WW'(TIMEOUT - 1);

    // state register, wait counter (cleared whenever a memory state is entered), retire counter, sticky faults
    always_ff @(posedge clk) begin
        if (reset) begin
            cur         <= FETCH;
            wait_cnt    <= '0;
            instret     <= '0;
            mem_timeout <= 1'b0;
            illegal_op  <= 1'b0;
        end else begin
            cur         <= nxt;
            wait_cnt    <= (mem_st && nxt == cur) ? wait_cnt + 1'b1 : '0;
            instret     <= (nxt == FETCH && cur != FETCH) ? instret + 1'b1 : instret;
            mem_timeout <= mem_timeout | tmo;
            illegal_op  <= illegal_op | bad_op;
        end
    end

    // next-state and per-state datapath controls
    always_comb begin
        nxt       = cur;
        MemReq    = 1'b0;
        PCWrite   = 1'b0;
        AdrSrc    = 1'b0;
        MemWrite  = 1'b0;
        IRWrite   = 1'b0;
        RegWrite  = 1'b0;
        ResultSrc = 2'b00;
        ALUSrcA   = 2'b00;
        ALUSrcB   = 2'b00;
        alu_op    = 2'b00;
        bad_op    = 1'b0;
        case (cur)
            FETCH: begin
                MemReq    = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                PCWrite   = mem_ready;
                IRWrite   = mem_ready;
                nxt       = mem_ready ? DECODE : tmo ? HALT : FETCH;
            end
            DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                case (op)
                    7'b0000011, 7'b0100011: nxt = MEMADR;
                    7'b0110011:             nxt = EXECR;
                    7'b0010011:             nxt = EXECI;
                    7'b1101111:             nxt = JAL;
                    7'b1100011:             nxt = BEQ;
                    default: begin
                        nxt    = HALT;
                        bad_op = 1'b1;
                    end
                endcase
            end
            MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                nxt     = op == 7'b0000011 ? MEMREAD : MEMWRITE;
            end
            MEMREAD: begin
                MemReq = 1'b1;
                AdrSrc = 1'b1;
                nxt    = mem_ready ? MEMWB : tmo ? HALT : MEMREAD;
            end
            MEMWB: begin
                ResultSrc = 2'b01;
                RegWrite  = 1'b1;
                nxt       = FETCH;
            end
            MEMWRITE: begin
                MemReq   = 1'b1;
                AdrSrc   = 1'b1;
                MemWrite = mem_ready;
                nxt      = mem_ready ? FETCH : tmo ? HALT : MEMWRITE;
            end
            EXECR: begin
                ALUSrcA = 2'b10;
                alu_op  = 2'b10;
                nxt     = ALUWB;
            end
            EXECI: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                alu_op  = 2'b10;
                nxt     = ALUWB;
            end
            ALUWB: begin
                RegWrite = 1'b1;
                nxt      = FETCH;
            end
            JAL: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b10;
                PCWrite = 1'b1;
                nxt     = FETCH;
            end
            BEQ: begin
                ALUSrcA = 2'b10;
                alu_op  = 2'b01;
                PCWrite = Zero;
                nxt     = FETCH;
            end
            default: nxt = HALT;
        endcase
    end

    // ALU operation decode; only register/immediate ALU ops consult funct3
    always_comb begin
        ALUControl = 3'b000;
        if (alu_op == 2'b01)
            ALUControl = 3'b001;
        else if (alu_op == 2'b10)
            ALUControl = funct3 == 3'b000 ? {2'b00, op[5] & funct7b5} :
                         funct3 == 3'b010 ? 3'b101 :
                         funct3 == 3'b110 ? 3'b011 :
                         funct3 == 3'b111 ? 3'b010 : 3'b000;
    end

    // immediate format select, decoded from the opcode in every state
    always_comb begin
        ImmSrc = op == 7'b0100011 ? 2'b01 :
                 op == 7'b1100011 ? 2'b10 :
                 op == 7'b1101111 ? 2'b11 : 2'b00;
    end
endmodule

// File: tb/tb_mc_controller_hs.sv
// tb_mc_controller_hs: instruction-level reference model driving two controllers (32-bit and 4-bit retire counters)
module tb_mc_controller_hs;
    localparam int TO = 15;

    logic clk, reset, funct7b5, Zero, mem_ready;
    logic [6:0] op;
    logic [2:0] funct3;
    logic MemReq, PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, mem_timeout, illegal_op;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
    logic [2:0] ALUControl;
    logic [31:0] instret;
    logic [3:0] state;
    logic s_MemReq, s_PCWrite, s_AdrSrc, s_MemWrite, s_IRWrite, s_RegWrite, s_mem_timeout, s_illegal_op;
    logic [1:0] s_ResultSrc, s_ALUSrcA, s_ALUSrcB, s_ImmSrc;
    logic [2:0] s_ALUControl;
    logic [3:0] s_instret;
    logic [3:0] s_state;
    logic [22:0] obs, obs_s;

    mc_controller_hs #(.CNT_W(32), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5), .Zero(Zero),
        .mem_ready(mem_ready), .MemReq(MemReq), .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite),
        .IRWrite(IRWrite), .RegWrite(RegWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ImmSrc(ImmSrc), .ALUControl(ALUControl), .instret(instret), .mem_timeout(mem_timeout),
        .illegal_op(illegal_op), .state(state)
    );

    mc_controller_hs #(.CNT_W(4), .TIMEOUT(TO)) dut_s (
        .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5), .Zero(Zero),
        .mem_ready(mem_ready), .MemReq(s_MemReq), .PCWrite(s_PCWrite), .AdrSrc(s_AdrSrc), .MemWrite(s_MemWrite),
        .IRWrite(s_IRWrite), .RegWrite(s_RegWrite), .ResultSrc(s_ResultSrc), .ALUSrcA(s_ALUSrcA), .ALUSrcB(s_ALUSrcB),
        .ImmSrc(s_ImmSrc), .ALUControl(s_ALUControl), .instret(s_instret), .mem_timeout(s_mem_timeout),
        .illegal_op(s_illegal_op), .state(s_state)
    );

    assign obs = {state, MemReq, PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
                  ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl, mem_timeout, illegal_op};
    assign obs_s = {s_state, s_MemReq, s_PCWrite, s_AdrSrc, s_MemWrite, s_IRWrite, s_RegWrite,
                    s_ResultSrc, s_ALUSrcA, s_ALUSrcB, s_ImmSrc, s_ALUControl, s_mem_timeout, s_illegal_op};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          st;
        bit          rdy;
        logic [6:0]  op;
        logic [2:0]  f3;
        bit          f7;
        bit          z;
        logic [31:0] ei;
        bit          to;
        bit          ill;
    } step_t;

    step_t       plan[$];
    logic [81:0] got_q[$];
    logic [31:0] m_ret;
    bit          m_to, m_ill, c_f7, c_z;
    logic [6:0]  c_op;
    logic [2:0]  c_f3;
    int          total, bad;

    // expected outputs for one cycle, from the per-state table and the decode rules
    function automatic logic [22:0] model_obs(input step_t s);
        logic mr, pw, ad, mw, iw, rw;
        logic [1:0] rs, sa, sb, aop, imm;
        logic [2:0] alu;
        {mr, pw, ad, mw, iw, rw} = '0;
        {rs, sa, sb, aop} = '0;
        case (s.st)
            0:  begin mr = 1; pw = s.rdy; iw = s.rdy; sb = 2; rs = 2; end
            1:  begin sa = 1; sb = 1; end
            2:  begin sa = 2; sb = 1; end
            3:  begin mr = 1; ad = 1; end
            4:  begin rs = 1; rw = 1; end
            5:  begin mr = 1; ad = 1; mw = s.rdy; end
            6:  begin sa = 2; aop = 2; end
            7:  rw = 1;
            8:  begin sa = 2; sb = 1; aop = 2; end
            9:  begin sa = 1; sb = 2; pw = 1; end
            10: begin sa = 2; aop = 1; pw = s.z; end
            default: ;
        endcase
        alu = aop == 1 ? 3'd1 : aop != 2 ? 3'd0 :
              s.f3 == 0 ? ((s.op[5] && s.f7) ? 3'd1 : 3'd0) :
              s.f3 == 2 ? 3'd5 : s.f3 == 6 ? 3'd3 : s.f3 == 7 ? 3'd2 : 3'd0;
        imm = s.op == 7'h23 ? 2'd1 : s.op == 7'h63 ? 2'd2 : s.op == 7'h6F ? 2'd3 : 2'd0;
        return {4'(s.st), mr, pw, ad, mw, iw, rw, rs, sa, sb, imm, alu, s.to, s.ill};
    endfunction

    task automatic add(input int st, input bit rdy);
        plan.push_back('{st, rdy, c_op, c_f3, c_f7, c_z, m_ret, m_to, m_ill});
    endtask

    task automatic add_halt();
        for (int i = 0; i < 3; i++) add(11, 1'($urandom));
    endtask

    // a memory access that waits w cycles; w >= TO means it never completes
    task automatic add_mem(input int st, input int w, output bit dead);
        dead = 0;
        for (int i = 0; i < w && i < TO; i++) add(st, 0);
        if (w >= TO) begin
            m_to = 1;
            add_halt();
            dead = 1;
        end else add(st, 1);
    endtask

    // expected cycle sequence of one instruction by class
    task automatic add_instr(input logic [6:0] o, input logic [2:0] f, input bit s, input bit z,
                             input int wf, input int wm);
        bit dead;
        c_op = o; c_f3 = f; c_f7 = s; c_z = z;
        add_mem(0, wf, dead);
        if (dead) return;
        add(1, 1'($urandom));
        case (o)
            7'b0000011: begin
                add(2, 1'($urandom));
                add_mem(3, wm, dead);
                if (!dead) begin add(4, 1'($urandom)); m_ret++; end
            end
            7'b0100011: begin
                add(2, 1'($urandom));
                add_mem(5, wm, dead);
                if (!dead) m_ret++;
            end
            7'b0110011: begin add(6, 1'($urandom)); add(7, 1'($urandom)); m_ret++; end
            7'b0010011: begin add(8, 1'($urandom)); add(7, 1'($urandom)); m_ret++; end
            7'b1101111: begin add(9, 1'($urandom)); m_ret++; end
            7'b1100011: begin add(10, 1'($urandom)); m_ret++; end
            default: begin m_ill = 1; add_halt(); end
        endcase
    endtask

    task automatic play();
        got_q.delete();
        foreach (plan[i]) begin
            op = plan[i].op; funct3 = plan[i].f3; funct7b5 = plan[i].f7;
            Zero = plan[i].z; mem_ready = plan[i].rdy;
            #1;
            got_q.push_back({obs, instret, obs_s, s_instret});
            @(negedge clk);
        end
    endtask

    task automatic do_reset();
        reset = 1; mem_ready = 1;
        @(negedge clk);
        reset = 0;
        m_ret = 0; m_to = 0; m_ill = 0;
        plan.delete();
    endtask

    task automatic test_reset();
        logic [81:0] e;
        do_reset();
        add_instr(7'h33, 3'd0, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) add(0, 0);
        play();
        for (int i = 0; i < plan.size(); i++) begin
            e = {model_obs(plan[i]), plan[i].ei, model_obs(plan[i]), plan[i].ei[3:0]};
            total++;
            if (got_q[i] !== e) begin bad++; $display("FAIL reset_pre cyc %0d got %h want %h", i, got_q[i], e); end
        end
        do_reset();
        add_instr(7'h33, 3'd7, 0, 0, 14, 0);
        add(0, 0);
        play();
        for (int i = 0; i < plan.size(); i++) begin
            e = {model_obs(plan[i]), plan[i].ei, model_obs(plan[i]), plan[i].ei[3:0]};
            total++;
            if (got_q[i] !== e) begin bad++; $display("FAIL reset_post cyc %0d got %h want %h", i, got_q[i], e); end
        end
    endtask

    task automatic test_rtype();
        logic [81:0] e;
        do_reset();
        add_instr(7'h33, 3'd0, 1, 0, 0, 0);
        add(0, 0);
        play();
        for (int i = 0; i < plan.size(); i++) begin
            e = {model_obs(plan[i]), plan[i].ei, model_obs(plan[i]), plan[i].ei[3:0]};
            total++;
            if (got_q[i] !== e) begin bad++; $display("FAIL rtype cyc %0d got %h want %h", i, got_q[i], e); end
        end
    endtask

    task automatic test_mem_wait();
        logic [81:0] e;
        do_reset();
        add_instr(7'h03, 3'd2, 0, 0, 0, 3);
        add_instr(7'h23, 3'd2, 1, 1, 14, 14);
        add_instr(7'h03, 3'd2, 0, 0, 14, 14);
        add(0, 0);
        play();
        for (int i = 0; i < plan.size(); i++) begin
            e = {model_obs(plan[i]), plan[i].ei, model_obs(plan[i]), plan[i].ei[3:0]};
            total++;
            if (got_q[i] !== e) begin bad++; $display("FAIL mem_wait cyc %0d got %h want %h", i, got_q[i], e); end
        end
    endtask

    task automatic test_timeout();
        logic [81:0] e;
        do_reset();
        add_instr(7'h33, 3'd0, 0, 0, TO, 0);
        play();
        for (int i = 0; i < plan.size(); i++) begin
            e = {model_obs(plan[i]), plan[i].ei, model_obs(plan[i]), plan[i].ei[3:0]};
            total++;
            if (got_q[i] !== e) begin bad++; $display("FAIL timeout_fetch cyc %0d got %h want %h", i, got_q[i], e); end
        end
        do_reset();
        add_instr(7'h13, 3'd6, 0, 0, 2, 0);
        add_instr(7'h03, 3'd2, 0, 0, 0, TO);
        play();
        for (int i = 0; i < plan.size(); i++) begin
            e = {model_obs(plan[i]), plan[i].ei, model_obs(plan[i]), plan[i].ei[3:0]};
            total++;
            if (got_q[i] !== e) begin bad++; $display("FAIL timeout_read cyc %0d got %h want %h", i, got_q[i], e); end
        end
    endtask

    task automatic test_beq();
        logic [81:0] e;
        do_reset();
        add_instr(7'h63, 3'd0, 0, 1, 0, 0);
        add_instr(7'h63, 3'd0, 1, 0, 1, 0);
        add_instr(7'h6F, 3'd0, 0, 1, 0, 0);
        add(0, 0);
        play();
        for (int i = 0; i < plan.size(); i++) begin
            e = {model_obs(plan[i]), plan[i].ei, model_obs(plan[i]), plan[i].ei[3:0]};
            total++;
            if (got_q[i] !== e) begin bad++; $display("FAIL beq cyc %0d got %h want %h", i, got_q[i], e); end
        end
    endtask

    task automatic test_illegal();
        logic [81:0] e;
        do_reset();
        add_instr(7'h33, 3'd0, 0, 0, 0, 0);
        add_instr(7'h7F, 3'd0, 0, 0, 0, 0);
        play();
        for (int i = 0; i < plan.size(); i++) begin
            e = {model_obs(plan[i]), plan[i].ei, model_obs(plan[i]), plan[i].ei[3:0]};
            total++;
            if (got_q[i] !== e) begin bad++; $display("FAIL illegal cyc %0d got %h want %h", i, got_q[i], e); end
        end
        do_reset();
        add_instr(7'h13, 3'd0, 1, 0, 1, 0);
        add(0, 0);
        play();
        for (int i = 0; i < plan.size(); i++) begin
            e = {model_obs(plan[i]), plan[i].ei, model_obs(plan[i]), plan[i].ei[3:0]};
            total++;
            if (got_q[i] !== e) begin bad++; $display("FAIL illegal_clear cyc %0d got %h want %h", i, got_q[i], e); end
        end
    endtask

    task automatic test_wrap();
        logic [81:0] e;
        do_reset();
        for (int k = 0; k < 16; k++) add_instr(7'h33, 3'(k), 1'(k), 0, 0, 0);
        add(0, 0);
        play();
        for (int i = 0; i < plan.size(); i++) begin
            e = {model_obs(plan[i]), plan[i].ei, model_obs(plan[i]), plan[i].ei[3:0]};
            total++;
            if (got_q[i] !== e) begin bad++; $display("FAIL wrap cyc %0d got %h want %h", i, got_q[i], e); end
        end
    endtask

    task automatic test_random();
        logic [81:0] e;
        logic [6:0] ops [6];
        ops = '{7'h03, 7'h23, 7'h33, 7'h13, 7'h6F, 7'h63};
        do_reset();
        for (int k = 0; k < 40; k++)
            add_instr(ops[$urandom_range(5, 0)], 3'($urandom), 1'($urandom), 1'($urandom),
                      int'($urandom_range(4, 0)), int'($urandom_range(4, 0)));
        add(0, 0);
        play();
        for (int i = 0; i < plan.size(); i++) begin
            e = {model_obs(plan[i]), plan[i].ei, model_obs(plan[i]), plan[i].ei[3:0]};
            total++;
            if (got_q[i] !== e) begin bad++; $display("FAIL random cyc %0d got %h want %h", i, got_q[i], e); end
        end
    endtask

    initial begin
        total = 0; bad = 0;
        reset = 1; mem_ready = 0; op = 0; funct3 = 0; funct7b5 = 0; Zero = 0;
        @(negedge clk);
        test_reset();
        test_rtype();
        test_mem_wait();
        test_timeout();
        test_beq();
        test_illegal();
        test_wrap();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
